// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for the E stage: one quotient bit per cycle, then a single ready pulse.
// Optional macro DIV_FAST_PATH_EN lets a zero divisor or |a| < |b| skip the iterations.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic             cancel,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall_div,
    output logic             ready,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_div0;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_lo_fin;
    logic [WIDTH-1:0] w_hi_fin;
    logic             w_last;

    assign w_accept = (r_state == S_IDLE) && startE && !cancel;
    assign w_a_neg  = signedE && srca[WIDTH-1];
    assign w_b_neg  = signedE && srcb[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -srca : srca;
    assign w_abs_b  = w_b_neg ? -srcb : srcb;

    // The shifted partial remainder needs one extra bit before the trial subtraction.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    // Divide by zero reports the raw dividend, bypassing sign correction.
    assign w_lo_fin = r_div0 ? '1 : (r_q_neg ? -w_quo_next : w_quo_next);
    assign w_hi_fin = r_div0 ? r_a_raw : (r_r_neg ? -w_rem_next : w_rem_next);

`ifdef DIV_FAST_PATH_EN
    logic w_fast;
    assign w_fast = (srcb == '0) || (w_abs_a < w_abs_b);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_a_raw <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_abs_a;
                        r_div   <= w_abs_b;
                        r_a_raw <= srca;
                        r_q_neg <= w_a_neg ^ w_b_neg;
                        r_r_neg <= w_a_neg;
                        r_div0  <= (srcb == '0);
`ifdef DIV_FAST_PATH_EN
                        if (w_fast) begin
                            r_lo    <= (srcb == '0) ? '1 : '0;
                            r_hi    <= srca;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
`else
                        r_state <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_lo    <= w_lo_fin;
                            r_hi    <= w_hi_fin;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Cancel releases the pipeline in the same cycle it is raised.
    assign stall_div = w_accept || ((r_state == S_BUSY) && !cancel);
    assign ready     = (r_state == S_DONE);
    assign lo_out    = r_lo;
    assign hi_out    = r_hi;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: driver queues expected results, monitor checks on each ready pulse.
module tb_div_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         startE;
    logic         signedE;
    logic         cancel;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         stall_div;
    logic         ready;
    logic [W-1:0] lo_out;
    logic [W-1:0] hi_out;

    div_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .startE(startE), .signedE(signedE), .cancel(cancel),
        .srca(srca), .srcb(srcb), .stall_div(stall_div), .ready(ready),
        .lo_out(lo_out), .hi_out(hi_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           rcyc;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, cyc, act, req);
        end
    endtask

    // Reference: plain integer division on 64-bit values; C-style truncation matches DIV/DIVU.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi, output bit fast);
        longint sa, sb, q, r, ma, mb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        fast = (b == 0) || (ma < mb);
        if (b == 0) begin
            lo = '1;
            hi = a;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[W-1:0];
            hi = r[W-1:0];
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready cyc=%0d actual=1 required=0", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("lo_out", lo_out, mon_e.lo);
                check("hi_out", hi_out, mon_e.hi);
                check("ready_cycle", W'(cyc), W'(mon_e.rcyc));
                $display("txn cyc=%0d lo=0x%08h hi=0x%08h", cyc, lo_out, hi_out);
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] elo, ehi;
        bit           fast;
        int           t, lat;
        @(posedge clk); #1;
        startE = 1'b1; signedE = s; srca = a; srcb = b; cancel = 1'b0;
        model(a, b, s, elo, ehi, fast);
        t = cyc;
`ifdef DIV_FAST_PATH_EN
        lat = fast ? 1 : W + 1;
`else
        lat = W + 1;
`endif
        sb_q.push_back('{elo, ehi, t + lat});
        last_lo = elo;
        last_hi = ehi;
        @(negedge clk);
        check("stall_accept", W'(stall_div), 1);
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            startE = 1'b0; srca = $urandom; srcb = $urandom; signedE = 1'($urandom);
            @(negedge clk);
            check("stall_busy", W'(stall_div), 1);
        end
        // A start seen in DONE belongs to the completing instruction and must not be taken.
        @(posedge clk); #1;
        startE = 1'($urandom); srca = $urandom; srcb = $urandom;
        @(negedge clk);
        check("stall_done", W'(stall_div), 0);
        startE = 1'b0;
    endtask

    task automatic cancel_test();
        @(posedge clk); #1;
        startE = 1'b1; signedE = 1'b0; srca = 100; srcb = 7;
        @(negedge clk);
        check("cancel_stall_accept", W'(stall_div), 1);
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
            startE = 1'b0;
            @(negedge clk);
            check("cancel_stall_busy", W'(stall_div), 1);
        end
        @(posedge clk); #1;
        cancel = 1'b1;
        @(negedge clk);
        check("cancel_stall_drop", W'(stall_div), 0);
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_stall_idle", W'(stall_div), 0);
        check("cancel_lo_kept", lo_out, last_lo);
        check("cancel_hi_kept", hi_out, last_hi);
        do_op(100, 7, 1'b0);
    endtask

    task automatic reset_test();
        @(posedge clk); #1;
        startE = 1'b1; signedE = 1'b1; srca = 32'hFFFF_0000; srcb = 3;
        @(negedge clk);
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #1;
            startE = 1'b0;
            rst = (k == 5);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_lo", lo_out, 0);
        check("rst_mid_hi", hi_out, 0);
        check("rst_mid_stall", W'(stall_div), 0);
        check("rst_mid_ready", W'(ready), 0);
        last_lo = '0;
        last_hi = '0;
        repeat (40) @(posedge clk);
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        rst = 1'b1; startE = 1'b0; signedE = 1'b0; cancel = 1'b0; srca = '0; srcb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", W'(ready), 0);
        check("reset_stall", W'(stall_div), 0);
        check("reset_lo", lo_out, 0);
        check("reset_hi", hi_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(100, 7, 1'b0);
        do_op(32'hFFFF_FFF9, 2, 1'b1);
        do_op(7, 32'hFFFF_FFFE, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op(5, 0, 1'b0);
        do_op(3, 10, 1'b0);
        do_op(32'hFFFF_FFF0, 0, 1'b1);
        do_op(32'hFFFF_FFFF, 1, 1'b0);
        cancel_test();
        reset_test();

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: a = W'($urandom_range(0, 20));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                default: ;
            endcase
            do_op(a, b, s);
        end

        repeat (5) @(posedge clk);
        check("queue_drained", W'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle iterative radix-2 divider with its own sequencing FSM, serving the execute stage of the 5-stage MIPS pipeline.
- Accepts a DIV/DIVU request from E, holds the pipeline stalled while it iterates, then presents quotient and remainder for the HI/LO write.
- The hazard unit consumes stall_div; the hilo register consumes lo_out/hi_out when ready is high.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- startE  input  1  a divide instruction is in E (divE).
- signedE  input  1  1 = DIV (signed), 0 = DIVU (hassignE).
- cancel  input  1  flush of E (flushE); aborts the operation.
- srca  input  WIDTH  dividend.
- srcb  input  WIDTH  divisor.
- stall_div  output  1  freezes F/D/E; also blocks M from advancing the divide.
- ready  output  1  one-cycle pulse; results valid.
- lo_out  output  WIDTH  quotient.
- hi_out  output  WIDTH  remainder.

Behaviour:
- States: IDLE, BUSY, DONE. Reset forces IDLE, cnt=0, lo_out=0, hi_out=0, ready=0; stall_div therefore reads 0.
- Accept:
  - In IDLE with startE=1 and cancel=0, latch srca, srcb and signedE; clear cnt; go to BUSY.
  - For a signed request, latch the magnitudes, plus sign flags: quotient is negative = sign(a) XOR sign(b); remainder is negative = sign(a).
- BUSY:
  - One restoring step per cycle: shift {rem,quo} left by 1; subtract |b| from rem.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore.
  - cnt increments each step. After step WIDTH (cnt==WIDTH-1), go to DONE.
- DONE:
  - Apply sign correction (two's complement) to quotient and remainder, register them to lo_out/hi_out, and assert ready for exactly this cycle.
  - Next state is IDLE. startE is ignored in DONE because it belongs to the completing instruction.
- stall_div = (IDLE & startE & ~cancel) | BUSY. It is 0 in DONE, so the pipeline advances in the ready cycle.
- Latency: accept at cycle T, ready at T+WIDTH+1; stall_div is high for cycles T..T+WIDTH (WIDTH+1 cycles).
- lo_out/hi_out hold their last values until the next DONE.
- Divide by zero: lo_out=all ones, hi_out=srca (raw, no sign correction); full latency still applies.
- Signed overflow, most-negative / -1: lo_out=0x80000000, hi_out=0.
- cancel in BUSY: go to IDLE on the next edge; no ready; outputs unchanged; stall_div drops that same cycle.
- cancel in DONE: ready is still asserted; the hilo write is gated by the pipeline, not here.
- rst mid-operation: IDLE on the next edge; outputs cleared.
- startE and cancel both high in IDLE: no accept.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined: on accept, if srcb==0 or |srca|<|srcb|, go directly to DONE (results: q=0, r=srca for the magnitude case; divide-by-zero values as above).
  - ready then comes at T+1, and stall_div is high only in cycle T.
- Undefined: every divide takes the full WIDTH+1 cycles.

Test Plan:
- DIVU 100/7 accepted at cycle 0 -> stall_div high cycles 0..32, ready at cycle 33, lo=14, hi=2.
- DIV -7/2 (0xFFFFFFF9 / 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- Accept 100/7, assert cancel at cycle 10 -> stall_div 0 from cycle 10, no ready, lo/hi keep prior values.
  - A new accept at cycle 12 completes normally at cycle 45.
- rst at cycle 5 of an operation -> IDLE, lo/hi=0, no ready. Back-to-back: second startE in the cycle after DONE is accepted.
- With DIV_FAST_PATH_EN: DIVU 3/10 -> ready at cycle 1, lo=0, hi=3. Without the macro -> ready at cycle 33.
